dual_issue_scoreboard: RTL and testbench
========================================

// Module: dual_issue_scoreboard
// PURPOSE
//  Issue stage directly downstream of the dual-instruction decoder. Accepts one
//  decoded pair per handshake (ins_1 older, ins_2 younger) into a 2-slot buffer.
//  Tracks pending register writes with per-register countdown counters and issues
//  0, 1 or 2 instructions per cycle, in order. Back-pressures decode via in_ready.
// PARAMETERS
//  ALU_LAT  1  cycles register result is busy after issue, ops 1-B (range 1..7)
//  MEM_LAT  3  cycles register result is busy after issue of LOAD (range 1..7)
// PORTS
//  clk        in   1  clock, all state on posedge
//  rst_n      in   1  reset, asynchronous, active-low
//  in_valid   in   1  decoded pair present on ins_* fields
//  in_ready   out  1  buffer accepts pair this cycle
//  ins_N_op   in   4  opcode, N=1,2 (also ins_N_des/s1/s2 [3:0], ins_N_ime [4:0])
//  iss_N_valid out 1  issue slot N valid, N=1,2 (iss_1 always the older)
//  iss_N_op/des/s1/s2 out 4, iss_N_ime out 5  issued instruction fields
// BEHAVIOUR
//  Op classes: 0 NOP (no read/write); 1-7 ALU reads s1,s2 writes des;
//   8-B ALU-imm reads s1 writes des; C LOAD reads s1 writes des (mem);
//   D STORE reads s1,des no write (mem); E BRANCH reads s1,s2 no write; F = NOP.
//  r0 never busy; writes to des=0 never set a counter; reads of r0 never stall.
//  Scoreboard: cnt[r] 3 bits, r=1..15. Each cycle cnt!=0 decrements by 1. Issuing
//   a writer to r loads cnt[r]=ALU_LAT or MEM_LAT on the same edge (load wins
//   over decrement). Register busy <=> cnt!=0.
//  Buffer: slots A (older) and B. Pair accepted (in_valid&&in_ready) loads A=ins_1,
//   B=ins_2. in_ready = 1 iff no slot will remain occupied after this cycle's
//   issue (depends on state only, never on in_valid).
//  Issue decision (combinational on current state, outputs registered):
//   A issues iff occupied and none of its read regs / write reg busy.
//   B issues iff A issues (or A empty) and B's regs not busy and no pair hazard:
//   RAW (B reads A.des, A writes, des!=0), WAW (same nonzero des, both write),
//   both memory ops (C/D) -> B held.
//  If A issues and B does not, B moves to A next cycle. If A empty, B -> iss_1.
//  Outputs: iss_1 carries oldest issued, iss_2 the younger; iss_2_valid implies
//   iss_1_valid. Valid deasserted cycles hold fields at last value.
//  Latency: accepted pair earliest on iss_* one cycle after acceptance edge.
//   Consumer of a result issues LAT+1 cycles after producer's issue decision.
//  NOPs occupy a slot and are issued with valid=1 (no hazards).
//  Reset (async, rst_n=0): all cnt=0, slots empty, iss_*_valid=0, iss fields 0,
//   in_ready=1 after release. Reset mid-operation discards buffered pair and
//   pending busy state; nothing issued until new pair accepted.
// TESTING
//  1 pair ADD r1=r2+r3, ADD r4=r5+r6, empty sb -> both valid next cycle, in_ready
//    stays 1, next pair accepted back-to-back.
//  2 ADD r1=r2+r3, ADD r4=r1+r5 -> cycle1 iss_1 only; second issues as iss_1 2
//    cycles later (ALU_LAT=1); in_ready=0 while held.
//  3 LOAD r7, then pair ADD r8=r7+r1 -> ADD stalls until cnt[r7]=0, issues
//    MEM_LAT+1 cycles after LOAD decision.
//  4 ADD r0=r1+r2, ADD r3=r0+r0 -> both issue same cycle (r0 never hazard).
//  5 LOAD r2 + STORE r4 pair -> structural: LOAD issues, STORE next cycle.
//  6 hold pair with busy r9, assert rst_n=0 mid-stall -> valids 0 immediately,
//    in_ready=1 after release, held pair never issued.

Source files
------------

// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard: in-order dual-issue stage with per-register busy countdown scoreboard
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         handshake for one decoded pair (ins_1 older, ins_2 younger)
//   ins_N_op/des/s1/s2/ime      decoded instruction fields, N=1,2
//   iss_N_valid                 registered issue slot valids (iss_1 always the older)
//   iss_N_op/des/s1/s2/ime      registered issued fields, held while valid is low
module dual_issue_scoreboard #(
    parameter int ALU_LAT = 1,
    parameter int MEM_LAT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] ins_1_op,
    input  logic [3:0] ins_1_des,
    input  logic [3:0] ins_1_s1,
    input  logic [3:0] ins_1_s2,
    input  logic [4:0] ins_1_ime,
    input  logic [3:0] ins_2_op,
    input  logic [3:0] ins_2_des,
    input  logic [3:0] ins_2_s1,
    input  logic [3:0] ins_2_s2,
    input  logic [4:0] ins_2_ime,
    output logic       iss_1_valid,
    output logic [3:0] iss_1_op,
    output logic [3:0] iss_1_des,
    output logic [3:0] iss_1_s1,
    output logic [3:0] iss_1_s2,
    output logic [4:0] iss_1_ime,
    output logic       iss_2_valid,
    output logic [3:0] iss_2_op,
    output logic [3:0] iss_2_des,
    output logic [3:0] iss_2_s1,
    output logic [3:0] iss_2_s2,
    output logic [4:0] iss_2_ime
);
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] des;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [4:0] ime;
    } ins_t;

    function automatic logic rd1(input logic [3:0] op);
        return op != 4'h0 && op != 4'hF;
    endfunction

    function automatic logic rd2(input logic [3:0] op);
        return (op >= 4'h1 && op <= 4'h7) || op == 4'hE;
    endfunction

    function automatic logic rdd(input logic [3:0] op);
        return op == 4'hD;
    endfunction

    function automatic logic wr(input logic [3:0] op);
        return op >= 4'h1 && op <= 4'hC;
    endfunction

    function automatic logic mem(input logic [3:0] op);
        return op == 4'hC || op == 4'hD;
    endfunction

    // The write register is checked too, so a younger writer never overtakes a pending one.
    function automatic logic blocked(input ins_t i, input logic [15:0] bz);
        return (rd1(i.op) && bz[i.s1]) || (rd2(i.op) && bz[i.s2]) ||
               ((rdd(i.op) || wr(i.op)) && bz[i.des]);
    endfunction

    ins_t in1, in2, a, b, o1, o2;
    logic a_v, b_v, iss_a, iss_b, pair_hz, acc;
    logic [15:0] bsy;
    logic [2:0] cnt [15:1];

    assign in1 = '{ins_1_op, ins_1_des, ins_1_s1, ins_1_s2, ins_1_ime};
    assign in2 = '{ins_2_op, ins_2_des, ins_2_s1, ins_2_s2, ins_2_ime};

    always_comb begin
        bsy = '0;
        for (int r = 1; r < 16; r++) bsy[r] = cnt[r] != 3'd0;
    end

    always_comb begin
        pair_hz = (wr(a.op) && a.des != 4'd0 &&
                   ((rd1(b.op) && b.s1 == a.des) || (rd2(b.op) && b.s2 == a.des) ||
                    ((rdd(b.op) || wr(b.op)) && b.des == a.des))) ||
                  (mem(a.op) && mem(b.op));
        iss_a = a_v && !blocked(a, bsy);
        iss_b = b_v && (iss_a || !a_v) && !blocked(b, bsy) && !(a_v && pair_hz);
    end

    // Ready only when the buffer drains completely this cycle; a function of state alone.
    assign in_ready = !(a_v && !iss_a) && !(b_v && !iss_b);
    assign acc = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < 16; r++) cnt[r] <= 3'd0;
        end else begin
            for (int r = 1; r < 16; r++)
                if (iss_a && wr(a.op) && a.des == 4'(r))
                    cnt[r] <= a.op == 4'hC ? 3'(MEM_LAT) : 3'(ALU_LAT);
                else if (iss_b && wr(b.op) && b.des == 4'(r))
                    cnt[r] <= b.op == 4'hC ? 3'(MEM_LAT) : 3'(ALU_LAT);
                else if (cnt[r] != 3'd0)
                    cnt[r] <= cnt[r] - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a   <= '0;
            b   <= '0;
            a_v <= 1'b0;
            b_v <= 1'b0;
        end else if (acc) begin
            a   <= in1;
            b   <= in2;
            a_v <= 1'b1;
            b_v <= 1'b1;
        end else if (a_v && !iss_a) begin
            a_v <= 1'b1;
        end else if (b_v && !iss_b) begin
            a   <= b;
            a_v <= 1'b1;
            b_v <= 1'b0;
        end else begin
            a_v <= 1'b0;
            b_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_1_valid <= 1'b0;
            iss_2_valid <= 1'b0;
            o1          <= '0;
            o2          <= '0;
        end else begin
            iss_1_valid <= iss_a || iss_b;
            iss_2_valid <= iss_a && iss_b;
            if (iss_a || iss_b) o1 <= iss_a ? a : b;
            if (iss_a && iss_b) o2 <= b;
        end
    end

    assign {iss_1_op, iss_1_des, iss_1_s1, iss_1_s2, iss_1_ime} = o1;
    assign {iss_2_op, iss_2_des, iss_2_s1, iss_2_s2, iss_2_ime} = o2;
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// tb_dual_issue_scoreboard: directed scoreboard bench for dual_issue_scoreboard
module tb_dual_issue_scoreboard;
    typedef logic [20:0] ins_t;
    typedef struct {
        int   cyc;
        int   slot;
        ins_t ins;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    ins_t in1 = '0;
    ins_t in2 = '0;
    logic iss_1_valid, iss_2_valid;
    logic [3:0] iss_1_op, iss_1_des, iss_1_s1, iss_1_s2;
    logic [3:0] iss_2_op, iss_2_des, iss_2_s1, iss_2_s2;
    logic [4:0] iss_1_ime, iss_2_ime;

    exp_t q[$];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    dual_issue_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ins_1_op(in1[20:17]), .ins_1_des(in1[16:13]), .ins_1_s1(in1[12:9]),
        .ins_1_s2(in1[8:5]), .ins_1_ime(in1[4:0]),
        .ins_2_op(in2[20:17]), .ins_2_des(in2[16:13]), .ins_2_s1(in2[12:9]),
        .ins_2_s2(in2[8:5]), .ins_2_ime(in2[4:0]),
        .iss_1_valid(iss_1_valid), .iss_1_op(iss_1_op), .iss_1_des(iss_1_des),
        .iss_1_s1(iss_1_s1), .iss_1_s2(iss_1_s2), .iss_1_ime(iss_1_ime),
        .iss_2_valid(iss_2_valid), .iss_2_op(iss_2_op), .iss_2_des(iss_2_des),
        .iss_2_s1(iss_2_s1), .iss_2_s2(iss_2_s2), .iss_2_ime(iss_2_ime)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic ins_t mk(input int op, input int des, input int s1, input int s2, input int ime);
        return {4'(op), 4'(des), 4'(s1), 4'(s2), 5'(ime)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int c, input int s, input ins_t i);
        exp_t e;
        e.cyc = c;
        e.slot = s;
        e.ins = i;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input int slot, input ins_t got);
        exp_t e;
        n_chk++;
        if (q.size() == 0) begin
            $display("FAIL unexpected_issue: slot %0d ins %h at cycle %0d, nothing expected", slot, got, cyc);
        end else begin
            e = q.pop_front();
            if (e.cyc == cyc && e.slot == slot && e.ins == got) n_pass++;
            else $display("FAIL issue: got slot %0d ins %h cycle %0d, expected slot %0d ins %h cycle %0d",
                          slot, got, cyc, e.slot, e.ins, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (iss_2_valid) chk("iss2_implies_iss1", int'(iss_1_valid), 1);
            if (iss_1_valid) pop_cmp(1, {iss_1_op, iss_1_des, iss_1_s1, iss_1_s2, iss_1_ime});
            if (iss_2_valid) pop_cmp(2, {iss_2_op, iss_2_des, iss_2_s1, iss_2_s2, iss_2_ime});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input ins_t i1, input ins_t i2, output int k);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("send_timeout", int'(in_ready), 1);
        in1 = i1;
        in2 = i2;
        in_valid = 1'b1;
        @(negedge clk);
        k = cyc;
        in_valid = 1'b0;
    endtask

    initial begin
        int k, k2, w;
        ins_t a, b, c, d, nop;
        nop = mk(0, 6, 5, 4, 3);
        idle(2);
        chk("rst_iss1_valid", int'(iss_1_valid), 0);
        chk("rst_iss2_valid", int'(iss_2_valid), 0);
        chk("rst_iss1_fields", int'({iss_1_op, iss_1_des, iss_1_s1, iss_1_s2, iss_1_ime}), 0);
        chk("rst_iss2_fields", int'({iss_2_op, iss_2_des, iss_2_s1, iss_2_s2, iss_2_ime}), 0);
        rst_n = 1'b1;
        idle(1);
        chk("rst_in_ready", int'(in_ready), 1);

        // independent pair, then back-to-back pair
        a = mk(1, 1, 2, 3, 0);
        b = mk(1, 4, 5, 6, 0);
        send(a, b, k);
        push(k + 1, 1, a);
        push(k + 1, 2, b);
        chk("t1_ready", int'(in_ready), 1);
        c = mk(2, 7, 8, 9, 1);
        d = mk(3, 10, 11, 12, 2);
        send(c, d, k2);
        chk("t1_back_to_back", k2, k + 1);
        push(k2 + 1, 1, c);
        push(k2 + 1, 2, d);
        idle(4);

        // RAW inside the pair on an ALU result
        a = mk(1, 1, 2, 3, 0);
        b = mk(1, 4, 1, 5, 0);
        send(a, b, k);
        push(k + 1, 1, a);
        push(k + 3, 1, b);
        chk("t2_ready_held0", int'(in_ready), 0);
        idle(1);
        chk("t2_ready_held1", int'(in_ready), 0);
        idle(1);
        chk("t2_ready_free", int'(in_ready), 1);
        idle(4);

        // consumer of a LOAD result waits MEM_LAT+1 cycles
        a = mk(12, 7, 1, 0, 5);
        send(a, nop, k);
        push(k + 1, 1, a);
        push(k + 1, 2, nop);
        b = mk(1, 8, 7, 1, 0);
        send(b, nop, k2);
        chk("t3_accept", k2, k + 1);
        chk("t3_ready_stall", int'(in_ready), 0);
        push(k + 5, 1, b);
        push(k + 5, 2, nop);
        idle(8);

        // r0 is never a hazard
        a = mk(1, 0, 1, 2, 0);
        b = mk(1, 3, 0, 0, 0);
        send(a, b, k);
        push(k + 1, 1, a);
        push(k + 1, 2, b);
        idle(3);

        // two memory ops in one pair issue on consecutive cycles
        a = mk(12, 2, 1, 0, 4);
        b = mk(13, 4, 3, 0, 8);
        send(a, b, k);
        push(k + 1, 1, a);
        push(k + 2, 1, b);
        idle(6);

        // reset while a pair is held on busy r9
        a = mk(12, 9, 1, 0, 0);
        send(a, nop, k);
        push(k + 1, 1, a);
        push(k + 1, 2, nop);
        b = mk(1, 10, 9, 1, 0);
        send(b, nop, k2);
        idle(1);
        chk("t6_held_ready", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_iss1_valid", int'(iss_1_valid), 0);
        chk("t6_rst_iss2_valid", int'(iss_2_valid), 0);
        chk("t6_rst_iss1_op", int'(iss_1_op), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_ready_after_rst", int'(in_ready), 1);
        idle(6);
        c = mk(1, 11, 9, 1, 0);
        send(c, nop, k);
        push(k + 1, 1, c);
        push(k + 1, 2, nop);

        w = 0;
        while (q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        idle(2);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
